// File: rtl/boreal_pkg.sv
// Shared types and default constants for the feature burst sequencer.
package boreal_pkg;

  localparam int unsigned DEF_N_CH = 8;
  localparam int unsigned DEF_W    = 16;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_STREAM  = 2'd2
  } state_e;

endpackage

// File: rtl/feature_burst_seq_chan_pick.sv
// chan_pick: lowest enabled channel at or above start_i, plus a flag telling
// whether it is the highest enabled channel.
module chan_pick
  import boreal_pkg::*;
#(
  parameter int unsigned N_CH = DEF_N_CH,
  parameter int unsigned IW   = 3
) (
  input  logic [N_CH-1:0] mask_i,
  input  logic [IW:0]     start_i,
  output logic [IW-1:0]   next_o,
  output logic            last_o
);

  logic [IW-1:0] nxt;
  logic          found;

  // Ascending priority search, then scan for any enabled channel above it.
  always_comb begin
    nxt    = '0;
    found  = 1'b0;
    last_o = 1'b1;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (!found && mask_i[i] && (i >= int'(start_i))) begin
        nxt   = IW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < int'(N_CH); i++) begin
      if (mask_i[i] && (i > int'(nxt))) begin
        last_o = 1'b0;
      end
    end
    next_o = nxt;
  end

endmodule

// File: rtl/feature_burst_seq.sv
// feature_burst_seq: snapshots per-channel feature strobes and serializes a
// frame of enabled channels onto a valid/ready stream.
// Optional: BOREAL_CHAN_MASK_EN adds the chan_mask port (sampled per frame).
module feature_burst_seq
  import boreal_pkg::*;
#(
  parameter int unsigned N_CH    = DEF_N_CH,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      halt,
  input  logic [N_CH*W-1:0]         ch_feat,
  input  logic [N_CH-1:0]           ch_ready,
`ifdef BOREAL_CHAN_MASK_EN
  input  logic [N_CH-1:0]           chan_mask,
`endif
  output logic [W-1:0]              out_data,
  output logic [$clog2(N_CH)-1:0]   out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      frame_done,
  output logic                      overrun,
  output logic                      timeout_err
);

  localparam int unsigned IW = $clog2(N_CH);
  localparam int unsigned SW = IW + 1;

  state_e                   state_q, state_d;
  logic [N_CH-1:0]          pending_q, pending_d;
  logic [N_CH-1:0]          mask_q, mask_d;
  logic [N_CH-1:0][W-1:0]   snap_q, snap_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [W-1:0]             out_data_q, out_data_d;
  logic [IW-1:0]            out_ch_q, out_ch_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic                     frame_done_q, frame_done_d;
  logic                     overrun_q, overrun_d;
  logic                     timeout_err_q, timeout_err_d;

  logic [N_CH-1:0]          mask_src_c;
  logic [N_CH-1:0]          frame_mask_c;
  logic [N_CH-1:0]          cap_c;
  logic [SW-1:0]            pick_start_c;
  logic [IW-1:0]            pick_next_c;
  logic                     pick_last_c;
  logic                     load_first_c;

`ifdef BOREAL_CHAN_MASK_EN
  assign mask_src_c = chan_mask;
`else
  assign mask_src_c = '1;
`endif

  // Live mask while idle; the frame's latched mask once a frame has started.
  assign frame_mask_c = (state_q == ST_IDLE) ? mask_src_c : mask_q;

  // Search from channel 0 when a frame starts, else from the channel after the current beat.
  assign pick_start_c = (state_q == ST_STREAM) ? (SW'(out_ch_q) + SW'(1)) : '0;

  chan_pick #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_chan_pick (
    .mask_i  (frame_mask_c),
    .start_i (pick_start_c),
    .next_o  (pick_next_c),
    .last_o  (pick_last_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    mask_d        = mask_q;
    snap_d        = snap_q;
    cnt_d         = cnt_q;
    out_data_d    = out_data_q;
    out_ch_d      = out_ch_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    frame_done_d  = 1'b0;
    overrun_d     = overrun_q;
    timeout_err_d = 1'b0;
    cap_c         = '0;
    load_first_c  = 1'b0;

    if (halt) begin
      state_d     = ST_IDLE;
      pending_d   = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_COLLECT: begin
          cap_c = ch_ready & frame_mask_c;
          for (int i = 0; i < int'(N_CH); i++) begin
            if (cap_c[i]) snap_d[i] = ch_feat[i*W +: W];
          end
          pending_d = pending_q | cap_c;
          if (state_q == ST_IDLE) begin
            if (|cap_c) begin
              mask_d  = frame_mask_c;
              cnt_d   = '0;
              state_d = ST_COLLECT;
              if ((pending_d & frame_mask_c) == frame_mask_c) begin
                state_d      = ST_STREAM;
                load_first_c = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if ((pending_d & mask_q) == mask_q) begin
              state_d      = ST_STREAM;
              load_first_c = 1'b1;
            end else if (cnt_d == CNT_W'(TIMEOUT)) begin
              timeout_err_d = 1'b1;
              state_d       = ST_STREAM;
              load_first_c  = 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (|(ch_ready & mask_q)) overrun_d = 1'b1;
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              state_d      = ST_IDLE;
              pending_d    = '0;
              out_valid_d  = 1'b0;
              out_last_d   = 1'b0;
              frame_done_d = 1'b1;
            end else begin
              out_ch_d   = pick_next_c;
              out_data_d = snap_q[pick_next_c];
              out_last_d = pick_last_c;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // First beat comes straight from this cycle's snapshot update.
      if (load_first_c) begin
        out_valid_d = 1'b1;
        out_ch_d    = pick_next_c;
        out_data_d  = snap_d[pick_next_c];
        out_last_d  = pick_last_c;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      mask_q        <= '0;
      snap_q        <= '0;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_ch_q      <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      snap_q        <= snap_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
      out_ch_q      <= out_ch_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_ch      = out_ch_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule
